// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection light controller front end.
//   - Direction indices used for every 4-bit per-direction bus:
//     [0]=north, [1]=east, [2]=south, [3]=west.
//   - Queue counter width/type and default tuning values.
//   - Loop-debounce FSM state encoding.
//   - Saturating counter helpers used by the queue tracker.
// -----------------------------------------------------------------------------
package traffic_pkg;

  // Direction indices (bit positions in every per-direction bus).
  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;
  localparam int NUM_DIRS = 4;

  // Queue counter.
  localparam int QCNT_W = 4;
  typedef logic [QCNT_W-1:0] qcnt_t;

  // Default tuning values.
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MAX_Q           = 15;
  localparam int DEF_DEEP_THRESH     = 5;

  // Loop-debounce FSM states.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

  // Increment that sticks at max_v instead of wrapping.
  function automatic qcnt_t qcnt_sat_inc(input qcnt_t v, input qcnt_t max_v);
    return (v >= max_v) ? max_v : v + qcnt_t'(1);
  endfunction

  // Decrement that sticks at zero instead of wrapping.
  function automatic qcnt_t qcnt_sat_dec(input qcnt_t v);
    return (v == '0) ? '0 : v - qcnt_t'(1);
  endfunction

endpackage : traffic_pkg

// File: rtl/loop_debounce.sv
// -----------------------------------------------------------------------------
// loop_debounce
// Conditions one raw loop-detector level:
//   1. two-flop synchronizer (raw is asynchronous to clk),
//   2. STABLE/PENDING debounce FSM: a new synchronized level is accepted only
//      after it has persisted DEBOUNCE_CYCLES consecutive cycles,
//   3. one-cycle registered pulse on each accepted 0->1 change.
// Raw edge to pulse is 2 + DEBOUNCE_CYCLES cycles.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   raw    in   asynchronous loop level
//   ev     out  one-cycle pulse on an accepted rising level
//               ('event' is a reserved word, hence the short name)
// -----------------------------------------------------------------------------
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic ev
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  // Counter value during the last cycle of a persisting difference.
  localparam cnt_t CNT_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  deb_state_t state_q, state_d;
  cnt_t       cnt_q,   cnt_d;
  logic       stable_q, stable_d;
  logic       ev_q,    ev_d;

  logic       diff;

  assign diff = (sync2_q != stable_q);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    ev_d     = 1'b0;

    // cnt_q counts difference cycles already seen; it is 0 in STABLE, so the
    // cycle that enters PENDING is the first one of the run.
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (diff) begin
          if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
            ev_d     = ~stable_q;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = cnt_q + cnt_t'(1);
          end
        end
      end
      ST_PENDING: begin
        if (!diff) begin
          // Glitch: level fell back before the run completed.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_STABLE;
          cnt_d    = '0;
          stable_d = ~stable_q;
          ev_d     = ~stable_q;   // pulse only when the new level is 1
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      ev_q     <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      ev_q     <= ev_d;
    end
  end

  assign ev = ev_q;

endmodule : loop_debounce

// File: rtl/queue_sensor_tracker.sv
// -----------------------------------------------------------------------------
// queue_sensor_tracker
// Upstream stage of the intersection light controller. Debounces the arrival
// and stop-line loop of each direction, keeps a saturating queue count per
// direction and publishes registered occupancy vectors.
//
// Ports (bit order of every 4-bit bus: [0]=N [1]=E [2]=S [3]=W):
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   arrive_raw     in   4  asynchronous arrival-loop levels
//   depart_raw     in   4  asynchronous stop-line-loop levels
//   sensor_1th     out  4  registered, qcnt >= 1
//   sensor_5th     out  4  registered, qcnt >= DEEP_THRESH
//   underflow_err  out  4  sticky, departure seen while qcnt == 0
//   qcount_bus     out  16 registered {qcnt W,S,E,N}; present only when the
//                          macro QUEUE_COUNT_OUT_EN is defined
// -----------------------------------------------------------------------------
module queue_sensor_tracker
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MAX_Q           = DEF_MAX_Q,
  parameter int DEEP_THRESH     = DEF_DEEP_THRESH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  arrive_raw,
  input  logic [3:0]  depart_raw,
  output logic [3:0]  sensor_1th,
  output logic [3:0]  sensor_5th,
  output logic [3:0]  underflow_err
`ifdef QUEUE_COUNT_OUT_EN
  ,
  output logic [15:0] qcount_bus
`endif
);

  localparam qcnt_t MAX_Q_C  = qcnt_t'(MAX_Q);
  localparam qcnt_t DEEP_C   = qcnt_t'(DEEP_THRESH);

  logic [NUM_DIRS-1:0] arr_ev;
  logic [NUM_DIRS-1:0] dep_ev;

  qcnt_t               qcnt_q [NUM_DIRS];
  qcnt_t               qcnt_d [NUM_DIRS];
  logic [NUM_DIRS-1:0] sensor_1th_q,    sensor_1th_d;
  logic [NUM_DIRS-1:0] sensor_5th_q,    sensor_5th_d;
  logic [NUM_DIRS-1:0] underflow_err_q, underflow_err_d;

  // ---------------------------------------------------------------------------
  // Loop conditioning: one debouncer per raw input.
  // ---------------------------------------------------------------------------
  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    loop_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_arr_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (arrive_raw[d]),
      .ev    (arr_ev[d])
    );

    loop_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dep_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (depart_raw[d]),
      .ev    (dep_ev[d])
    );
  end

  // ---------------------------------------------------------------------------
  // Queue counters, threshold compares and sticky error flags.
  // Sensors are derived from qcnt_d so they change on the same edge as the
  // count and never lag it.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int d = 0; d < NUM_DIRS; d++) begin
      qcnt_d[d]          = qcnt_q[d];
      underflow_err_d[d] = underflow_err_q[d];

      // Simultaneous arrival and departure cancel: no change, no error.
      unique case ({arr_ev[d], dep_ev[d]})
        2'b10:   qcnt_d[d] = qcnt_sat_inc(qcnt_q[d], MAX_Q_C);
        2'b01: begin
          if (qcnt_q[d] == '0) begin
            underflow_err_d[d] = 1'b1;
          end
          qcnt_d[d] = qcnt_sat_dec(qcnt_q[d]);
        end
        default: qcnt_d[d] = qcnt_q[d];
      endcase

      sensor_1th_d[d] = (qcnt_d[d] != '0);
      sensor_5th_d[d] = (qcnt_d[d] >= DEEP_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIRS; d++) begin
        qcnt_q[d] <= '0;
      end
      sensor_1th_q    <= '0;
      sensor_5th_q    <= '0;
      underflow_err_q <= '0;
    end else begin
      for (int d = 0; d < NUM_DIRS; d++) begin
        qcnt_q[d] <= qcnt_d[d];
      end
      sensor_1th_q    <= sensor_1th_d;
      sensor_5th_q    <= sensor_5th_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign sensor_1th    = sensor_1th_q;
  assign sensor_5th    = sensor_5th_q;
  assign underflow_err = underflow_err_q;

`ifdef QUEUE_COUNT_OUT_EN
  // ---------------------------------------------------------------------------
  // Optional raw count export, registered alongside the sensor vectors.
  // ---------------------------------------------------------------------------
  logic [15:0] qcount_bus_q, qcount_bus_d;

  always_comb begin
    qcount_bus_d = {qcnt_d[DIR_W], qcnt_d[DIR_S], qcnt_d[DIR_E], qcnt_d[DIR_N]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qcount_bus_q <= '0;
    end else begin
      qcount_bus_q <= qcount_bus_d;
    end
  end

  assign qcount_bus = qcount_bus_q;
`endif

endmodule : queue_sensor_tracker
